perf_snapshot_streamer: RTL and testbench
=========================================

# perf_snapshot_streamer

Downstream consumer of the four cache performance counters (hit, miss, read, write). On a snapshot request, it captures all four counter values in the same clock edge, so the set is coherent. It then serialises the captured set as a framed word stream over a valid/ready interface toward the debug/host link. It never modifies the counters; it only samples their outputs.

## Interface
Parameters:
- COUNTER_WIDTHS, default 32: width of each incoming counter value.
- OUT_WIDTH, default 8: width of one output word.
  - Must be ≥ 8.
  - Must divide COUNTER_WIDTHS exactly.
  - Any other value is an elaboration error.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- hit_value  input  COUNTER_WIDTHS  live hit counter.
- miss_value  input  COUNTER_WIDTHS  live miss counter.
- read_value  input  COUNTER_WIDTHS  live read counter.
- write_value  input  COUNTER_WIDTHS  live write counter.
- snapshot_req  input  1  single-cycle request to capture and stream.
- out_ready  input  1  sink can accept a word this cycle.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  OUT_WIDTH  current stream word.
- out_last  output  1  current word is the final word of the frame.
- busy  output  1  a frame is captured or in flight.
- snapshot_dropped  output  1  one-cycle pulse: a request arrived while busy and was ignored.

## Operation
- CHUNKS = COUNTER_WIDTHS/OUT_WIDTH. FRAME_LEN = 1 + 4*CHUNKS (17 at defaults).
- Frame order:
  - One header word: 8'hA5, zero-extended to OUT_WIDTH.
  - Then hit, miss, read, write.
  - Each counter is sent most-significant chunk first.
- FSM states:
  - IDLE → HEADER: on snapshot_req=1. All four inputs are latched into a 4×COUNTER_WIDTHS shadow register at this edge. The word index is cleared.
  - HEADER → DATA: on a header handshake (out_valid & out_ready).
  - DATA: the word index increments on each handshake. After the handshake of word FRAME_LEN-1 (out_last=1), the FSM returns to IDLE.
- busy = (state != IDLE).
- snapshot_req while busy: ignored, and snapshot_dropped pulses the following cycle. The shadow register is not disturbed.
- snapshot_req in the same cycle as the last-word handshake: state is not yet IDLE, so the request is dropped and snapshot_dropped pulses.
- Shadow contents are frozen for the whole frame. Live counter changes during streaming do not appear in out_data.
- Counter wrap: values are sent as captured. No saturation or special handling of wrap-around.
- Reset (at any time, including mid-frame) forces:
  - state = IDLE
  - shadow = 0
  - word index = 0
  - The in-flight frame is abandoned. No partial completion and no out_last.

## Timing
- Reset values:
  - out_valid = 0
  - out_data = 0
  - out_last = 0
  - busy = 0
  - snapshot_dropped = 0
- Latency: snapshot_req sampled high at edge N → out_valid=1 with the header from edge N (visible in cycle N+1). busy=1 from the same edge.
- Handshake:
  - A word transfers on any rising edge where out_valid & out_ready.
  - While out_valid & !out_ready, out_data and out_last are held stable.
  - out_valid never drops mid-frame.
- Throughput: with out_ready held high, one word per cycle. The frame occupies FRAME_LEN consecutive cycles.
- After the last handshake at edge M: out_valid=0 and busy=0 in cycle M+1. A new request is accepted from edge M+1 onward.
- All outputs are registered. out_data is zero whenever out_valid=0.

## Test plan
- Basic frame: reset, hit=0x11223344, miss=0x55667788, read=0x0000_0001, write=0xFFFF_FFFF, pulse snapshot_req, out_ready=1 → 17 words: A5, 11, 22, 33, 44, 55, 66, 77, 88, 00, 00, 00, 01, FF, FF, FF, FF; out_last only on the 17th word; busy falls the cycle after.
- Coherence: change all inputs every cycle after capture → streamed words equal only the values present at the request edge.
- Backpressure: toggle out_ready pseudo-randomly (include a 5-cycle stall on word 3) → out_data/out_last stable during stalls; same 17-word sequence; no duplicates or skips.
- Dropped requests: pulse snapshot_req during word 8, and again in the cycle of the final handshake → snapshot_dropped pulses once for each; the frame is unchanged; no second frame. A request one cycle after busy falls starts a new frame.
- Reset mid-frame: assert reset during word 10 → out_valid, busy, and out_last go 0 immediately. After release with out_ready=1, no words appear until a new snapshot_req, and the new frame is complete and correct.
- Parameter variant: COUNTER_WIDTHS=16, OUT_WIDTH=16, hit=0xBEEF → 5-word frame: 0x00A5, 0xBEEF, then miss, read, write; out_last on word 5.

Source files
------------

// File: rtl/perf_stream_if.sv
// Word stream toward the debug/host link: valid/ready handshake with a frame-end marker.
`timescale 1ns/1ps
interface perf_stream_if #(
    parameter int OUT_WIDTH = 8
) ();
    logic                 out_valid;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;
    logic                 out_ready;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/perf_snapshot_streamer.sv
// Captures the four cache performance counters coherently on request and streams
// them as one framed word sequence: header 0xA5, then hit/miss/read/write MS chunk first.
`timescale 1ns/1ps
module perf_snapshot_streamer #(
    parameter int COUNTER_WIDTHS = 32,
    parameter int OUT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [COUNTER_WIDTHS-1:0] hit_value,
    input  logic [COUNTER_WIDTHS-1:0] miss_value,
    input  logic [COUNTER_WIDTHS-1:0] read_value,
    input  logic [COUNTER_WIDTHS-1:0] write_value,
    input  logic                      snapshot_req,
    perf_stream_if.master             stream,
    output logic                      busy,
    output logic                      snapshot_dropped
);
    localparam int CHUNKS    = COUNTER_WIDTHS / OUT_WIDTH;
    localparam int FRAME_LEN = 1 + 4 * CHUNKS;
    localparam int SHADOW_W  = 4 * COUNTER_WIDTHS;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(FRAME_LEN - 1);
    localparam logic [OUT_WIDTH-1:0] HEADER_WORD = OUT_WIDTH'(8'hA5);

    generate
        if (OUT_WIDTH < 8 || (COUNTER_WIDTHS % OUT_WIDTH) != 0) begin : g_bad_params
            $error("perf_snapshot_streamer: OUT_WIDTH must be >= 8 and divide COUNTER_WIDTHS");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    state_t                 state_r,  state_nx_s;
    logic [IDX_W-1:0]       idx_r,    idx_nx_s;
    logic [SHADOW_W-1:0]    shadow_r, shadow_nx_s;
    logic                   out_valid_r, out_valid_nx_s;
    logic [OUT_WIDTH-1:0]   out_data_r,  out_data_nx_s;
    logic                   out_last_r,  out_last_nx_s;
    logic                   busy_r,      busy_nx_s;
    logic                   dropped_r,   dropped_nx_s;
    logic                   handshake_s;

    // Word 0 is the header; word k>=1 is chunk k-1 of the flattened shadow, hit at the top.
    function automatic logic [OUT_WIDTH-1:0] select_word(
        input logic [IDX_W-1:0]    idx,
        input logic [SHADOW_W-1:0] flat
    );
        logic [OUT_WIDTH-1:0] word;
        word = HEADER_WORD;
        for (int k = 0; k < 4 * CHUNKS; k++) begin
            word = (idx == IDX_W'(k + 1)) ? flat[SHADOW_W - 1 - k * OUT_WIDTH -: OUT_WIDTH] : word;
        end
        return word;
    endfunction

    assign handshake_s = out_valid_r & stream.out_ready;

    // Next-state, capture and next registered outputs; outputs are computed from the
    // post-edge state so they are all plain flops.
    always_comb begin
        state_nx_s  = state_r;
        idx_nx_s    = idx_r;
        shadow_nx_s = shadow_r;
        case (state_r)
            ST_IDLE: begin
                if (snapshot_req) begin
                    state_nx_s  = ST_HEADER;
                    idx_nx_s    = {IDX_W{1'b0}};
                    shadow_nx_s = {hit_value, miss_value, read_value, write_value};
                end else begin
                    state_nx_s  = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (handshake_s) begin
                    state_nx_s = ST_DATA;
                    idx_nx_s   = IDX_W'(1);
                end else begin
                    state_nx_s = ST_HEADER;
                end
            end
            ST_DATA: begin
                if (handshake_s) begin
                    if (idx_r == LAST_IDX) begin
                        state_nx_s = ST_IDLE;
                        idx_nx_s   = {IDX_W{1'b0}};
                    end else begin
                        idx_nx_s   = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                idx_nx_s   = {IDX_W{1'b0}};
            end
        endcase

        out_valid_nx_s = (state_nx_s != ST_IDLE);
        busy_nx_s      = out_valid_nx_s;
        out_data_nx_s  = out_valid_nx_s ? select_word(idx_nx_s, shadow_nx_s) : {OUT_WIDTH{1'b0}};
        out_last_nx_s  = out_valid_nx_s && (idx_nx_s == LAST_IDX);
        // The last-word handshake cycle is still non-idle, so a request there is dropped too.
        dropped_nx_s   = snapshot_req && (state_r != ST_IDLE);
    end

    // State, shadow and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            idx_r       <= {IDX_W{1'b0}};
            shadow_r    <= {SHADOW_W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_WIDTH{1'b0}};
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            dropped_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            idx_r       <= idx_nx_s;
            shadow_r    <= shadow_nx_s;
            out_valid_r <= out_valid_nx_s;
            out_data_r  <= out_data_nx_s;
            out_last_r  <= out_last_nx_s;
            busy_r      <= busy_nx_s;
            dropped_r   <= dropped_nx_s;
        end
    end

    assign stream.out_valid = out_valid_r;
    assign stream.out_data  = out_data_r;
    assign stream.out_last  = out_last_r;
    assign busy             = busy_r;
    assign snapshot_dropped = dropped_r;
endmodule

// File: tb/tb_perf_snapshot_streamer.sv
// Directed bench for perf_snapshot_streamer: default 32/8 build plus a 16/16 variant.
`timescale 1ns/1ps
module tb_perf_snapshot_streamer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] hit, miss, rd, wr;
    logic        req, ready, busy, dropped;
    logic [15:0] hit16, miss16, rd16, wr16;
    logic        req16, ready16, busy16, dropped16;

    perf_stream_if #(.OUT_WIDTH(8))  sif ();
    perf_stream_if #(.OUT_WIDTH(16)) sif16 ();
    assign sif.out_ready   = ready;
    assign sif16.out_ready = ready16;

    perf_snapshot_streamer #(.COUNTER_WIDTHS(32), .OUT_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .hit_value(hit), .miss_value(miss), .read_value(rd), .write_value(wr),
        .snapshot_req(req), .stream(sif), .busy(busy), .snapshot_dropped(dropped)
    );

    perf_snapshot_streamer #(.COUNTER_WIDTHS(16), .OUT_WIDTH(16)) dut16 (
        .clk(clk), .reset(reset),
        .hit_value(hit16), .miss_value(miss16), .read_value(rd16), .write_value(wr16),
        .snapshot_req(req16), .stream(sif16), .busy(busy16), .snapshot_dropped(dropped16)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    logic [7:0] exp_words [17];
    localparam logic [7:0]  BASIC [17] = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                                           8'h77, 8'h88, 8'h00, 8'h00, 8'h00, 8'h01,
                                           8'hFF, 8'hFF, 8'hFF, 8'hFF};
    localparam logic [15:0] VAR16 [5] = '{16'h00A5, 16'hBEEF, 16'h1234, 16'h0001, 16'hFFFF};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void fill_exp(input logic [31:0] h, input logic [31:0] m,
                                     input logic [31:0] r, input logic [31:0] w);
        logic [31:0] vals [4];
        vals[0] = h; vals[1] = m; vals[2] = r; vals[3] = w;
        exp_words[0] = 8'hA5;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 4; k++)
                exp_words[1 + c * 4 + k] = vals[c][31 - 8 * k -: 8];
    endfunction

    // Called in the cycle after the request edge; walks the frame word by word.
    task automatic stream_frame(input bit scramble, input bit backp, input bit drops);
        int w;
        int cycles;
        int stall;
        bit drop_exp;
        bit req_now;
        w = 0; cycles = 0; stall = 0; drop_exp = 1'b0;
        while (w < 17 && cycles < 300) begin
            cycles++;
            check("valid", {31'd0, sif.out_valid}, 32'd1);
            check("data", {24'd0, sif.out_data}, {24'd0, exp_words[w]});
            check("last", {31'd0, sif.out_last}, {31'd0, (w == 16)});
            check("busy", {31'd0, busy}, 32'd1);
            check("dropped", {31'd0, dropped}, {31'd0, drop_exp});
            if (backp) begin
                if (w == 3 && stall < 5) begin
                    ready = 1'b0;
                    stall++;
                end else begin
                    ready = 1'($urandom_range(0, 1));
                end
            end else begin
                ready = 1'b1;
            end
            req_now = drops && ready && (w == 8 || w == 16);
            req = req_now;
            if (scramble) begin
                hit = $urandom; miss = $urandom; rd = $urandom; wr = $urandom;
            end
            tick();
            drop_exp = req_now;
            req = 1'b0;
            if (ready) w++;
        end
        if (w < 17) check("frame_timeout", w, 32'd17);
        check("dropped_end", {31'd0, dropped}, {31'd0, drop_exp});
        check("valid_end", {31'd0, sif.out_valid}, 32'd0);
        check("busy_end", {31'd0, busy}, 32'd0);
        check("last_end", {31'd0, sif.out_last}, 32'd0);
        check("data_end", {24'd0, sif.out_data}, 32'd0);
        ready = 1'b1;
    endtask

    task automatic request(input logic [31:0] h, input logic [31:0] m,
                           input logic [31:0] r, input logic [31:0] w);
        hit = h; miss = m; rd = r; wr = w;
        fill_exp(h, m, r, w);
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; ready = 1'b0;
        hit = 32'd0; miss = 32'd0; rd = 32'd0; wr = 32'd0;
        hit16 = 16'd0; miss16 = 16'd0; rd16 = 16'd0; wr16 = 16'd0;
        req16 = 1'b0; ready16 = 1'b0;
        tick(); tick();
        check("rst_valid", {31'd0, sif.out_valid}, 32'd0);
        check("rst_data", {24'd0, sif.out_data}, 32'd0);
        check("rst_last", {31'd0, sif.out_last}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_dropped", {31'd0, dropped}, 32'd0);
        reset = 1'b0;
        ready = 1'b1;
        tick();

        // Basic frame against the hand-written word table
        hit = 32'h11223344; miss = 32'h55667788; rd = 32'h00000001; wr = 32'hFFFFFFFF;
        for (int i = 0; i < 17; i++) exp_words[i] = BASIC[i];
        req = 1'b1;
        tick();
        req = 1'b0;
        stream_frame(1'b0, 1'b0, 1'b0);

        // Coherence: inputs scrambled every cycle while streaming
        request(32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F);
        stream_frame(1'b1, 1'b0, 1'b0);

        // Backpressure with a 5-cycle stall on word 3
        request(32'hCAFEF00D, 32'h13579BDF, 32'h2468ACE0, 32'h80000001);
        stream_frame(1'b0, 1'b1, 1'b0);

        // Dropped requests at word 8 and on the final handshake
        request(32'hA1B2C3D4, 32'hE5F60718, 32'h293A4B5C, 32'h6D7E8F90);
        stream_frame(1'b0, 1'b0, 1'b1);
        // Request one cycle after busy falls starts a fresh frame
        request(32'h00000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h00010000);
        stream_frame(1'b0, 1'b0, 1'b0);

        // Reset during word 10
        request(32'h0BADC0DE, 32'h11111111, 32'h22222222, 32'h33333333);
        repeat (10) tick();
        check("pre_rst_word10", {24'd0, sif.out_data}, {24'd0, exp_words[10]});
        #2 reset = 1'b1;
        #1;
        check("midrst_valid", {31'd0, sif.out_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_last", {31'd0, sif.out_last}, 32'd0);
        check("midrst_data", {24'd0, sif.out_data}, 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("postrst_idle_valid", {31'd0, sif.out_valid}, 32'd0);
            check("postrst_idle_busy", {31'd0, busy}, 32'd0);
        end
        request(32'h44556677, 32'h8899AABB, 32'hCCDDEEFF, 32'h10203040);
        stream_frame(1'b0, 1'b0, 1'b0);

        // 16/16 variant: five-word frame
        hit16 = 16'hBEEF; miss16 = 16'h1234; rd16 = 16'h0001; wr16 = 16'hFFFF;
        ready16 = 1'b1;
        req16 = 1'b1;
        tick();
        req16 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("v16_valid", {31'd0, sif16.out_valid}, 32'd1);
            check("v16_data", {16'd0, sif16.out_data}, {16'd0, VAR16[i]});
            check("v16_last", {31'd0, sif16.out_last}, {31'd0, (i == 4)});
            tick();
        end
        check("v16_valid_end", {31'd0, sif16.out_valid}, 32'd0);
        check("v16_busy_end", {31'd0, busy16}, 32'd0);
        check("v16_dropped", {31'd0, dropped16}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
